// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage : Y86-64 style fetch with PC predict, D register and RUN/WAIT_RET/HALTED FSM
// Revision    : 1.0
// ----------------------------------------------------------------------------
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_pc,
  input  logic [7:0]  imem_byte0,
  input  logic [71:0] imem_bytes,
  input  logic        imem_error,
  input  logic        stall_f,
  input  logic        bubble_d,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        d_valid,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_ra,
  output logic [3:0]  d_rb,
  output logic [63:0] d_valc,
  output logic [63:0] d_valp,
  output logic        halted
);

  localparam logic [2:0] C_STAT_AOK = 3'd1;
  localparam logic [2:0] C_STAT_HLT = 3'd2;
  localparam logic [2:0] C_STAT_ADR = 3'd3;
  localparam logic [2:0] C_STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_WAIT_RET = 2'd1,
    S_HALTED   = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } dreg_t;

  localparam dreg_t C_BUBBLE = '{
    valid: 1'b0, stat: C_STAT_AOK, icode: 4'h1, ifun: 4'h0,
    ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0
  };

  state_t      state_q;
  logic [63:0] pc_q;
  dreg_t       d_q;
  logic        halted_q;

  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_need_regids;
  logic        w_need_valc;
  logic        w_instr_valid;
  logic [2:0]  w_stat;
  logic [63:0] w_valc;
  logic [63:0] w_valp;
  logic [63:0] w_pred_pc;
  dreg_t       w_fetched;

  assign w_icode = imem_byte0[7:4];
  assign w_ifun  = imem_byte0[3:0];

  always_comb begin
    w_need_regids = 1'b0;
    w_need_valc   = 1'b0;
    w_instr_valid = 1'b0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: w_need_regids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        w_need_regids = 1'b1;
        w_need_valc   = 1'b1;
      end
      4'h7, 4'h8: w_need_valc = 1'b1;
      default: ;
    endcase
    case (w_icode)
      4'h6:                    w_instr_valid = (w_ifun <= 4'd3);
      4'h2, 4'h7:              w_instr_valid = (w_ifun <= 4'd6);
      4'h0, 4'h1, 4'h3, 4'h4,
      4'h5, 4'h8, 4'h9, 4'hA,
      4'hB:                    w_instr_valid = (w_ifun == 4'd0);
      default:                 w_instr_valid = 1'b0;
    endcase
  end

  assign w_stat = imem_error      ? C_STAT_ADR :
                  !w_instr_valid  ? C_STAT_INS :
                  (w_icode == 4'h0) ? C_STAT_HLT : C_STAT_AOK;

  assign w_valc    = w_need_regids ? imem_bytes[71:8] : imem_bytes[63:0];
  // Wraps modulo 2^64 by construction of the 64-bit sum.
  assign w_valp    = pc_q + 64'd1 + {63'd0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);
  assign w_pred_pc = (w_icode == 4'h7 || w_icode == 4'h8) ? w_valc : w_valp;

  assign w_fetched = '{
    valid: 1'b1, stat: w_stat, icode: w_icode, ifun: w_ifun,
    ra:    w_need_regids ? imem_bytes[7:4] : 4'hF,
    rb:    w_need_regids ? imem_bytes[3:0] : 4'hF,
    valc:  w_valc, valp: w_valp
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= 64'd0;
      state_q  <= S_RUN;
      d_q      <= C_BUBBLE;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      state_q  <= S_RUN;
      d_q      <= C_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      // bubble_d overrides the D load; the PC/state path still advances unless stalled.
      if (bubble_d) begin
        d_q <= C_BUBBLE;
      end else if (!stall_f) begin
        d_q <= (state_q == S_RUN) ? w_fetched : C_BUBBLE;
      end
      if (!stall_f && state_q == S_RUN) begin
        pc_q <= w_pred_pc;
        if (w_stat != C_STAT_AOK) begin
          state_q  <= S_HALTED;
          halted_q <= 1'b1;
        end else if (w_icode == 4'h9) begin
          state_q <= S_WAIT_RET;
        end
      end
    end
  end

  assign imem_pc = pc_q;
  assign d_valid = d_q.valid;
  assign d_stat  = d_q.stat;
  assign d_icode = d_q.icode;
  assign d_ifun  = d_q.ifun;
  assign d_ra    = d_q.ra;
  assign d_rb    = d_q.rb;
  assign d_valc  = d_q.valc;
  assign d_valp  = d_q.valp;
  assign halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_pc;
  logic [7:0]  imem_byte0;
  logic [71:0] imem_bytes;
  logic        imem_error = 1'b0;
  logic        stall_f = 1'b0;
  logic        bubble_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        d_valid;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_byte0(imem_byte0),
    .imem_bytes(imem_bytes), .imem_error(imem_error), .stall_f(stall_f),
    .bubble_d(bubble_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .d_valid(d_valid), .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_ra(d_ra), .d_rb(d_rb), .d_valc(d_valc), .d_valp(d_valp), .halted(halted)
  );

  always_comb begin
    logic [7:0] idx;
    imem_byte0 = mem[imem_pc[7:0]];
    imem_bytes = '0;
    for (int k = 1; k <= 9; k++) begin
      idx = imem_pc[7:0] + 8'(k);
      imem_bytes[8*k-1 -: 8] = mem[idx];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
    mem[1] = 8'h30; mem[2] = 8'hFC; mem[3] = 8'h0A;
    for (int i = 4; i <= 10; i++) mem[i] = 8'h00;
    mem[11] = 8'h60; mem[12] = 8'h23;
    mem[41] = 8'h80; mem[42] = 8'h70;
    for (int i = 43; i <= 49; i++) mem[i] = 8'h00;
    mem[8'h70] = 8'h70; mem[8'h71] = 8'h9C;
    for (int i = 8'h72; i <= 8'h78; i++) mem[i] = 8'h00;
    mem[8'h9C] = 8'h90;
    mem[51] = 8'h00;
    mem[8'h93] = 8'hF0;
    mem[8'h94] = 8'h65; mem[8'h95] = 8'h00;

    // Reset state
    #12;
    chk("rst_pc", imem_pc, 64'd0);
    chk("rst_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_icode", {60'd0, d_icode}, 64'd1);
    chk("rst_ra", {60'd0, d_ra}, 64'hF);
    chk("rst_stat", {61'd0, d_stat}, 64'd1);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // nop at 0, then irmovq at 1
    step();
    chk("nop_icode", {60'd0, d_icode}, 64'd1);
    chk("nop_valid", {63'd0, d_valid}, 64'd1);
    chk("nop_valp", d_valp, 64'd1);
    chk("nop_pc", imem_pc, 64'd1);
    step();
    chk("irm_icode", {60'd0, d_icode}, 64'd3);
    chk("irm_ra", {60'd0, d_ra}, 64'hF);
    chk("irm_rb", {60'd0, d_rb}, 64'hC);
    chk("irm_valc", d_valc, 64'd10);
    chk("irm_valp", d_valp, 64'd11);
    chk("irm_pc", imem_pc, 64'd11);

    // Stall 3 cycles
    stall_f = 1'b1;
    step(); step(); step();
    chk("stall_pc", imem_pc, 64'd11);
    chk("stall_icode", {60'd0, d_icode}, 64'd3);
    chk("stall_valp", d_valp, 64'd11);
    chk("stall_valid", {63'd0, d_valid}, 64'd1);

    // Stall + bubble
    bubble_d = 1'b1;
    step();
    chk("stb_valid", {63'd0, d_valid}, 64'd0);
    chk("stb_icode", {60'd0, d_icode}, 64'd1);
    chk("stb_pc", imem_pc, 64'd11);
    stall_f = 1'b0; bubble_d = 1'b0;

    // addq at 11
    step();
    chk("add_icode", {60'd0, d_icode}, 64'd6);
    chk("add_ra", {60'd0, d_ra}, 64'd2);
    chk("add_rb", {60'd0, d_rb}, 64'd3);
    chk("add_valp", d_valp, 64'd13);
    chk("add_stat", {61'd0, d_stat}, 64'd1);
    chk("add_pc", imem_pc, 64'd13);

    // bubble_d alone: D bubble, PC advances
    bubble_d = 1'b1;
    step();
    chk("bub_valid", {63'd0, d_valid}, 64'd0);
    chk("bub_pc", imem_pc, 64'd14);
    bubble_d = 1'b0;

    // Redirect wins over stall
    stall_f = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'd41;
    step();
    chk("rds_pc", imem_pc, 64'd41);
    chk("rds_valid", {63'd0, d_valid}, 64'd0);
    stall_f = 1'b0; redirect_valid = 1'b0;

    // call at 41
    step();
    chk("call_icode", {60'd0, d_icode}, 64'd8);
    chk("call_valc", d_valc, 64'h70);
    chk("call_valp", d_valp, 64'd50);
    chk("call_pc", imem_pc, 64'h70);
    // jmp at 0x70 to 0x9C
    step();
    chk("jmp_icode", {60'd0, d_icode}, 64'd7);
    chk("jmp_valc", d_valc, 64'h9C);
    chk("jmp_pc", imem_pc, 64'h9C);
    // ret at 0x9C
    step();
    chk("ret_icode", {60'd0, d_icode}, 64'd9);
    chk("ret_valid", {63'd0, d_valid}, 64'd1);
    chk("ret_pc", imem_pc, 64'h9D);
    step();
    chk("wret_valid", {63'd0, d_valid}, 64'd0);
    chk("wret_pc", imem_pc, 64'h9D);
    chk("wret_halted", {63'd0, halted}, 64'd0);
    step();
    chk("wret2_valid", {63'd0, d_valid}, 64'd0);
    chk("wret2_pc", imem_pc, 64'h9D);
    redirect_valid = 1'b1; redirect_pc = 64'd50;
    step();
    chk("rret_pc", imem_pc, 64'd50);
    redirect_valid = 1'b0;
    step();
    chk("run50_valid", {63'd0, d_valid}, 64'd1);
    chk("run50_valp", d_valp, 64'd51);
    chk("run50_pc", imem_pc, 64'd51);

    // halt at 51
    step();
    chk("hlt_stat", {61'd0, d_stat}, 64'd2);
    chk("hlt_halted", {63'd0, halted}, 64'd1);
    chk("hlt_pc", imem_pc, 64'd52);
    step();
    chk("hlt2_valid", {63'd0, d_valid}, 64'd0);
    chk("hlt2_pc", imem_pc, 64'd52);
    chk("hlt2_halted", {63'd0, halted}, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h93;
    step();
    chk("rhlt_halted", {63'd0, halted}, 64'd0);
    chk("rhlt_pc", imem_pc, 64'h93);
    redirect_valid = 1'b0;

    // Invalid icode F
    step();
    chk("insF_stat", {61'd0, d_stat}, 64'd4);
    chk("insF_halted", {63'd0, halted}, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h94;
    step();
    redirect_valid = 1'b0;
    // opq ifun 5
    step();
    chk("ins65_stat", {61'd0, d_stat}, 64'd4);
    chk("ins65_halted", {63'd0, halted}, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h10;
    step();
    redirect_valid = 1'b0; imem_error = 1'b1;
    step();
    chk("adr_stat", {61'd0, d_stat}, 64'd3);
    chk("adr_halted", {63'd0, halted}, 64'd1);
    imem_error = 1'b0;

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_valp", d_valp, 64'd0);
    chk("wrap_pc", imem_pc, 64'd0);
    chk("wrap_stat", {61'd0, d_stat}, 64'd1);

    // Async reset mid-WAIT_RET
    redirect_valid = 1'b1; redirect_pc = 64'h9C;
    step();
    redirect_valid = 1'b0;
    step();
    chk("ret2_valid", {63'd0, d_valid}, 64'd1);
    chk("ret2_pc", imem_pc, 64'h9D);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", imem_pc, 64'd0);
    chk("arst_valid", {63'd0, d_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", {63'd0, d_valid}, 64'd1);
    chk("post_rst_valp", d_valp, 64'd1);
    chk("post_rst_pc", imem_pc, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have the port: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port: rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-003 The module SHALL have the port: imem_pc, output, 64 bits, the fetch address driven to the instruction memory.
REQ-004 The module SHALL have the port: imem_byte0, input, 8 bits, the byte at imem_pc.
REQ-005 The module SHALL have the port: imem_bytes, input, 72 bits, the bytes at imem_pc+1..+9; byte pc+k is in bits [8k-1:8k-8].
REQ-006 The module SHALL have the port: imem_error, input, 1 bit, the fetch address is out of range.
REQ-007 The module SHALL have the port: stall_f, input, 1 bit, hold the PC and the D register.
REQ-008 The module SHALL have the port: bubble_d, input, 1 bit, load a bubble into the D register.
REQ-009 The module SHALL have the port: redirect_valid, input, 1 bit, a downstream PC correction (mispredict or ret).
REQ-010 The module SHALL have the port: redirect_pc, input, 64 bits, the corrected PC.
REQ-011 The module SHALL have these outputs forming the D register: d_valid 1, d_stat 3, d_icode 4, d_ifun 4, d_ra 4, d_rb 4, d_valc 64, d_valp 64.
REQ-012 The module SHALL have the port: halted, output, 1 bit, high while the FSM is in HALTED.

Function
REQ-013 Field split SHALL be: icode = imem_byte0[7:4]; ifun = imem_byte0[3:0]; rA = imem_bytes[7:4]; rB = imem_bytes[3:0].
REQ-014 need_regids SHALL be 1 for icode in {2,3,4,5,6,A,B}.
REQ-015 need_valc SHALL be 1 for icode in {3,4,5,7,8}.
REQ-016 valC SHALL be imem_bytes[71:8] when need_regids is 1, otherwise imem_bytes[63:0], little-endian.
REQ-017 When need_regids is 0, rA and rB SHALL be forced to F.
REQ-018 valP SHALL be pc + 1 + need_regids + 8*need_valc, computed modulo 2^64 (wrap permitted).
REQ-019 Instruction validity SHALL follow these rules:
- icode 0..B is valid;
- icode 6 requires ifun ≤ 3;
- icode 2 and 7 require ifun ≤ 6;
- all other icodes require ifun = 0;
- anything else is invalid.
REQ-020 Fetched stat SHALL be chosen with this priority:
- ADR (3) if imem_error;
- else INS (4) if invalid;
- else HLT (2) if icode = 0;
- else AOK (1).
REQ-021 Predicted next PC SHALL be valC for icode 7 or 8, and valP otherwise.
REQ-022 FSM states SHALL be RUN, WAIT_RET and HALTED.
REQ-023 In RUN, each unstalled cycle SHALL load the fetched fields into D with d_valid = 1 and PC <= predicted PC.
REQ-024 From RUN, a fetched icode 9 (ret) with stat AOK SHALL transition to WAIT_RET.
REQ-025 From RUN, a fetched stat other than AOK SHALL transition to HALTED.
REQ-026 In WAIT_RET the PC SHALL hold and D SHALL load a bubble each unstalled cycle until redirect_valid.
REQ-027 In HALTED the PC SHALL hold, D SHALL load a bubble each unstalled cycle, and halted SHALL be 1.
REQ-028 A bubble SHALL be: d_valid = 0, icode = 1, ifun = 0, ra = rb = F, valc = valp = 0, stat = AOK.
REQ-029 Update priority SHALL be, highest first:
- redirect_valid: PC <= redirect_pc, FSM -> RUN (squashes a pending halt or ret), D <= bubble;
- then bubble_d: D <= bubble, with the PC updating per state unless stall_f;
- then stall_f: PC, D and state hold.
REQ-030 When stall_f and bubble_d are both 1 (no redirect), D SHALL take a bubble, and the PC and state SHALL hold.
REQ-031 imem_pc SHALL equal the PC register combinationally; it SHALL have no added latency, so fetch-to-D is 1 cycle.

Reset
REQ-032 While rst_n = 0, outputs SHALL be asynchronously forced to: PC = 0, FSM = RUN, D = bubble, halted = 0.
REQ-033 On the first rising clk after rst_n deasserts, the module SHALL fetch at PC 0.
REQ-034 A reset asserted mid-operation SHALL discard any WAIT_RET or HALTED state immediately.

Verification
REQ-035 Bytes 30 FC 0A 00 00 00 00 00 00 00 at pc 1 -> next cycle d_icode = 3, d_ra = F, d_rb = C, d_valc = 10, d_valp = 11, PC = 11.
REQ-036 Call 80 70 00.. at pc 41 -> d_valc = 0x70, d_valp = 50, PC = 0x70; then ret 90 at 0x9C -> WAIT_RET with bubbles; redirect_valid with redirect_pc = 50 -> PC = 50, state RUN.
REQ-037 Halt byte 00 -> d_stat = HLT, halted = 1 next cycle, PC frozen and bubbles thereafter; then redirect_valid with redirect_pc = 0x93 -> halted = 0, state RUN.
REQ-038 Byte 0xF0, or 0x65 (opq ifun 5) -> d_stat = INS and HALTED; imem_error = 1 -> d_stat = ADR.
REQ-039 Simultaneous events:
- stall_f = 1 for 3 cycles -> PC and D unchanged;
- stall_f and bubble_d together -> d_valid = 0 and PC unchanged;
- redirect_valid with stall_f -> redirect wins.
REQ-040 PC = 0xFFFFFFFFFFFFFFFF on a nop -> d_valp = 0 (wrap); rst_n pulsed low mid-WAIT_RET -> PC = 0, d_valid = 0 without waiting for clk.
